// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/sub/logic ops, and shifts that step one bit per cycle.
// Results and flags are registered on DONE entry and held until the consumer accepts them.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         inA,
    input  logic [WIDTH-1:0]         inB,
    input  logic [$clog2(WIDTH)-1:0] inC,
    input  logic [2:0]               op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         ans,
    output logic                     zero,
    output logic                     carry,
    output logic                     ovf,
    output logic                     busy
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} stateT;
    typedef enum logic [2:0] {
        OP_SRA = 3'b000, OP_SRL = 3'b001, OP_SUB = 3'b010, OP_ADD = 3'b011,
        OP_SLL = 3'b100, OP_AND = 3'b101, OP_OR  = 3'b110, OP_XOR = 3'b111
    } opT;

    stateT            state, stateNext;
    opT               opIn, shOp;
    logic [WIDTH-1:0] shReg, shStep, resNext;
    logic [SHW-1:0]   shCnt;
    logic [WIDTH:0]   sumFull, diffFull;
    logic             resLoad, shLoad, cNext, vNext;

    assign opIn     = opT'(op);
    assign sumFull  = {1'b0, inA} + {1'b0, inB};
    // Zero-extended subtraction: the extra bit is the unsigned borrow.
    assign diffFull = {1'b0, inA} - {1'b0, inB};

    always_comb begin
        case (shOp)
            OP_SRA:  shStep = {shReg[WIDTH-1], shReg[WIDTH-1:1]};
            OP_SLL:  shStep = {shReg[WIDTH-2:0], 1'b0};
            default: shStep = {1'b0, shReg[WIDTH-1:1]};
        endcase
    end

    always_comb begin
        stateNext = state;
        resLoad   = 1'b0;
        shLoad    = 1'b0;
        resNext   = shStep;
        cNext     = 1'b0;
        vNext     = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    resLoad   = 1'b1;
                    stateNext = DONE;
                    case (opIn)
                        OP_ADD: begin
                            resNext = sumFull[WIDTH-1:0];
                            cNext   = sumFull[WIDTH];
                            vNext   = (inA[WIDTH-1] == inB[WIDTH-1]) &&
                                      (sumFull[WIDTH-1] != inA[WIDTH-1]);
                        end
                        OP_SUB: begin
                            resNext = diffFull[WIDTH-1:0];
                            cNext   = diffFull[WIDTH];
                            vNext   = (inA[WIDTH-1] != inB[WIDTH-1]) &&
                                      (diffFull[WIDTH-1] != inA[WIDTH-1]);
                        end
                        OP_AND:  resNext = inA & inB;
                        OP_OR:   resNext = inA | inB;
                        OP_XOR:  resNext = inA ^ inB;
                        default: begin
                            resNext = inA;
                            if (inC != '0) begin
                                resLoad   = 1'b0;
                                shLoad    = 1'b1;
                                stateNext = SHIFT;
                            end
                        end
                    endcase
                end
            end
            SHIFT: begin
                if (shCnt == SHW'(1)) begin
                    resLoad   = 1'b1;
                    stateNext = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= stateNext;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ans   <= '0;
            zero  <= 1'b0;
            carry <= 1'b0;
            ovf   <= 1'b0;
            shReg <= '0;
            shCnt <= '0;
            shOp  <= OP_SRL;
        end else begin
            if (shLoad) begin
                shReg <= inA;
                shCnt <= inC;
                shOp  <= opIn;
            end else if (state == SHIFT) begin
                shReg <= shStep;
                shCnt <= shCnt - SHW'(1);
            end
            if (resLoad) begin
                ans   <= resNext;
                zero  <= (resNext == '0);
                carry <= cNext;
                ovf   <= vNext;
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: accepted requests are modelled arithmetically and queued;
// a monitor checks latency, hold-stability, retention and results when outputs are consumed.
module tb_alu_seq;
    localparam int W   = 8;
    localparam int SHW = 3;

    logic           clk = 1'b0;
    logic           reset, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]   inA, inB, ans;
    logic [SHW-1:0] inC;
    logic [2:0]     op;
    logic           zero, carry, ovf, busy;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .inA(inA), .inB(inB), .inC(inC), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .ans(ans), .zero(zero), .carry(carry), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] ans;
        logic         z, c, v;
        int           lat;
        int           acc;
    } expT;

    expT         scoreQ[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lastAcc = -100;
    bit          prevValid = 0;
    bit          rndReady = 0;
    logic [10:0] held, retained = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    function automatic expT model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [SHW-1:0] k);
        expT    e;
        longint ua, ub, sa, sb, r, full, lo, hi;
        full = longint'(1) << W;
        hi   = full / 2 - 1;
        lo   = -(full / 2);
        ua   = longint'(a);
        ub   = longint'(b);
        sa   = (ua > hi) ? ua - full : ua;
        sb   = (ub > hi) ? ub - full : ub;
        e.c  = 1'b0;
        e.v  = 1'b0;
        case (o)
            3'b000:  r = sa >>> k;
            3'b001:  r = ua >> k;
            3'b100:  r = ua << k;
            3'b010: begin
                r   = ua - ub;
                e.c = (ua < ub);
                e.v = (sa - sb > hi) || (sa - sb < lo);
            end
            3'b011: begin
                r   = ua + ub;
                e.c = (r >= full);
                e.v = (sa + sb > hi) || (sa + sb < lo);
            end
            3'b101:  r = ua & ub;
            3'b110:  r = ua | ub;
            default: r = ua ^ ub;
        endcase
        r     = r & (full - 1);
        e.ans = r[W-1:0];
        e.z   = (r == 0);
        e.lat = ((o == 3'b000 || o == 3'b001 || o == 3'b100) && k != 0) ? int'(k) + 1 : 1;
        e.acc = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        expT e;
        if (reset !== 1'b1) begin
            scoreQ.delete();
            prevValid = 0;
            retained  = '0;
        end else begin
            if (out_valid === 1'b1) begin
                if (scoreQ.size() == 0) begin
                    fail("spurious_out_valid");
                end else begin
                    if (!prevValid) begin
                        chk("latency", cyc - scoreQ[0].acc, scoreQ[0].lat);
                        held = {ans, zero, carry, ovf};
                    end else begin
                        chk("hold_stable", {ans, zero, carry, ovf}, held);
                    end
                    if (out_ready === 1'b1) begin
                        e = scoreQ.pop_front();
                        chk("result", {ans, zero, carry, ovf}, {e.ans, e.z, e.c, e.v});
                        retained = {ans, zero, carry, ovf};
                    end
                end
            end else begin
                chk("retain", {ans, zero, carry, ovf}, retained);
            end
            prevValid = (out_valid === 1'b1);
            if (in_valid === 1'b1 && in_ready === 1'b1) begin
                if (cyc - lastAcc < 2) fail("accept_spacing");
                lastAcc = cyc;
                e       = model(op, inA, inB, inC);
                e.acc   = cyc;
                scoreQ.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rndReady) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [SHW-1:0] c);
        int n = 0;
        op = o; inA = a; inB = b; inC = c; in_valid = 1'b1;
        @(negedge clk);
        while (in_ready !== 1'b1) begin
            n++;
            if (n > 200) begin fail("accept_timeout"); break; end
            tick();
            @(negedge clk);
        end
        tick();
        in_valid = 1'b0;
        inA = W'($urandom); inB = W'($urandom); inC = SHW'($urandom); op = 3'($urandom);
    endtask

    task automatic directed(input string nm, input logic [2:0] o, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [SHW-1:0] c,
                            input logic [W-1:0] expAns, input logic z, input logic cy, input logic v);
        int n = 0;
        issue(o, a, b, c);
        @(negedge clk);
        while (out_valid !== 1'b1) begin
            n++;
            if (n > 20) begin fail({nm, "_timeout"}); break; end
            tick();
            @(negedge clk);
        end
        chk(nm, {ans, zero, carry, ovf}, {expAns, z, cy, v});
        tick();
    endtask

    task automatic drain();
        int n = 0;
        rndReady  = 0;
        out_ready = 1'b1;
        while (scoreQ.size() != 0 || busy !== 1'b0) begin
            n++;
            if (n > 500) begin fail("drain_timeout"); break; end
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        inA = '0; inB = '0; inC = '0; op = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ans_flags", {ans, zero, carry, ovf}, '0);
        tick();
        reset = 1'b1;
        tick();

        directed("sra_90_3",  3'b000, 8'h90, 8'h00, 3'd3, 8'hF2, 1'b0, 1'b0, 1'b0);
        directed("srl_90_3",  3'b001, 8'h90, 8'h00, 3'd3, 8'h12, 1'b0, 1'b0, 1'b0);
        directed("sll_81_1",  3'b100, 8'h81, 8'h00, 3'd1, 8'h02, 1'b0, 1'b0, 1'b0);
        directed("sra_k0",    3'b000, 8'hA5, 8'h00, 3'd0, 8'hA5, 1'b0, 1'b0, 1'b0);
        directed("sll_80_7",  3'b100, 8'h80, 8'h00, 3'd7, 8'h00, 1'b1, 1'b0, 1'b0);
        directed("add_7f_01", 3'b011, 8'h7F, 8'h01, 3'd5, 8'h80, 1'b0, 1'b0, 1'b1);
        directed("add_ff_01", 3'b011, 8'hFF, 8'h01, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0);
        directed("sub_00_01", 3'b010, 8'h00, 8'h01, 3'd0, 8'hFF, 1'b0, 1'b1, 1'b0);
        directed("sub_80_01", 3'b010, 8'h80, 8'h01, 3'd0, 8'h7F, 1'b0, 1'b0, 1'b1);
        directed("and",       3'b101, 8'hF0, 8'h3C, 3'd2, 8'h30, 1'b0, 1'b0, 1'b0);
        directed("or",        3'b110, 8'hF0, 8'h0F, 3'd0, 8'hFF, 1'b0, 1'b0, 1'b0);
        directed("xor_zero",  3'b111, 8'hAA, 8'hAA, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Backpressure: result held while a competing request is presented.
        out_ready = 1'b0;
        issue(3'b011, 8'h12, 8'h34, 3'd0);
        in_valid = 1'b1; op = 3'b111; inA = 8'h55; inB = 8'h0F;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_ans", ans, 8'h46);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("bp_idle", {in_ready, busy, out_valid}, 3'b100);
        tick();

        // Reset in the middle of a long shift.
        issue(3'b000, 8'h80, 8'h00, 3'd7);
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_state", {out_valid, busy, in_ready}, 3'b001);
        chk("midrst_ans", {ans, zero, carry, ovf}, '0);
        repeat (12) tick();

        for (int i = 0; i < 4; i++) issue(3'b011, 8'(8'h40 * i + 3), 8'(8'h31 + i), 3'd0);
        drain();

        rndReady = 1;
        for (int i = 0; i < 150; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = W'($urandom);
            if ($urandom_range(0, 4) == 0) a = (i % 2 == 0) ? 8'h7F : 8'h80;
            issue(3'($urandom_range(0, 7)), a, b, SHW'($urandom_range(0, 7)));
        end
        drain();
        chk("scoreboard_empty", scoreQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
